// File: rtl/memory_island_port_arbiter_pkg.sv
// Shared helpers for the memory-island port arbiter.
//   idx_width(n) : bits needed to index n requesters (at least 1)
//   ByteWidth    : bits per strobe lane
package memory_island_port_arbiter_pkg;

  localparam int unsigned ByteWidth = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_island_port_arbiter_fifo.sv
// ID FIFO holding the requester index of each granted-but-unanswered transaction.
// No fall-through: a pushed entry becomes visible at data_o the cycle after the push.
//   clk_i/rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i/data_i: enqueue an entry (ignored when full)
//   pop_i/data_o : dequeue the head entry (ignored when empty)
//   full_o/empty_o/usage_o : occupancy; usage_o wraps to 0 when full
module memory_island_port_arbiter_fifo #(
  parameter  int unsigned DataWidth = 1,
  parameter  int unsigned Depth     = 4,
  localparam int unsigned AddrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [AddrW-1:0]     usage_o
);

  localparam int unsigned CntW = AddrW + 1;

  logic [Depth-1:0][DataWidth-1:0] mem_q;
  logic [AddrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  function automatic logic [AddrW-1:0] nxt(input logic [AddrW-1:0] p);
    return (p == AddrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q[AddrW-1:0];
  assign data_o  = mem_q[rd_q];
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) wr_d = nxt(wr_q);
    if (pop)  rd_d = nxt(rd_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      mem_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= data_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);

endmodule

// File: rtl/memory_island_port_arbiter.sv
// Round-robin arbiter sharing one memory-island port among NumInp requesters.
// Requests pass through combinationally (latency 0); a request that is presented
// but not granted is locked so it cannot be preempted. Granted indices are queued
// in an ID FIFO so in-order responses are routed back to their issuer.
//   clk_i, rst_ni             : clock, async active-low reset
//   in_*                      : per-requester request/response channels
//   out_*                     : shared memory port
//   outstanding_o             : granted transactions still awaiting a response
module memory_island_port_arbiter
  import memory_island_port_arbiter_pkg::*;
#(
  parameter  int unsigned NumInp         = 2,
  parameter  int unsigned AddrWidth      = 32,
  parameter  int unsigned DataWidth      = 32,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned StrbWidth      = DataWidth / ByteWidth,
  localparam int unsigned IdxWidth       = idx_width(NumInp),
  localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumInp-1:0]                   in_req_i,
  output logic [NumInp-1:0]                   in_gnt_o,
  input  logic [NumInp-1:0][AddrWidth-1:0]    in_addr_i,
  input  logic [NumInp-1:0]                   in_we_i,
  input  logic [NumInp-1:0][DataWidth-1:0]    in_wdata_i,
  input  logic [NumInp-1:0][StrbWidth-1:0]    in_strb_i,
  output logic [NumInp-1:0]                   in_rvalid_o,
  input  logic [NumInp-1:0]                   in_rready_i,
  output logic [NumInp-1:0][DataWidth-1:0]    in_rdata_o,
  output logic                                out_req_o,
  input  logic                                out_gnt_i,
  output logic [AddrWidth-1:0]                out_addr_o,
  output logic                                out_we_o,
  output logic [DataWidth-1:0]                out_wdata_o,
  output logic [StrbWidth-1:0]                out_strb_o,
  input  logic                                out_rvalid_i,
  output logic                                out_rready_o,
  input  logic [DataWidth-1:0]                out_rdata_i,
  output logic [CntWidth-1:0]                 outstanding_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] strb;
  } mem_req_t;

  localparam int unsigned FifoAddrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic [IdxWidth-1:0]  rr_q, rr_d, lock_sel_q, lock_sel_d, rr_sel, sel, head;
  logic                 lock_q, lock_d, rr_hit, req_sel, push, pop, full, empty;
  logic [FifoAddrW-1:0] usage;
  mem_req_t             sel_req;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    rr_sel = rr_q;
    rr_hit = 1'b0;
    for (int k = 0; k < NumInp; k++) begin
      if (!rr_hit && in_req_i[IdxWidth'((int'(rr_q) + k) % NumInp)]) begin
        rr_hit = 1'b1;
        rr_sel = IdxWidth'((int'(rr_q) + k) % NumInp);
      end
    end
  end

  assign sel     = lock_q ? lock_sel_q : rr_sel;
  assign req_sel = lock_q ? in_req_i[lock_sel_q] : rr_hit;
  // No pop bypass: a full FIFO blocks issue even if a response retires this cycle.
  assign out_req_o = req_sel & ~full;
  assign push      = out_req_o & out_gnt_i;

  // Payload is forced to zero when nothing is issued so the port stays quiet.
  always_comb begin
    sel_req = '0;
    if (out_req_o) begin
      sel_req.addr  = in_addr_i[sel];
      sel_req.we    = in_we_i[sel];
      sel_req.wdata = in_wdata_i[sel];
      sel_req.strb  = in_strb_i[sel];
    end
  end

  assign out_addr_o  = sel_req.addr;
  assign out_we_o    = sel_req.we;
  assign out_wdata_o = sel_req.wdata;
  assign out_strb_o  = sel_req.strb;

  always_comb begin
    in_gnt_o = '0;
    if (push) in_gnt_o[sel] = 1'b1;
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = out_req_o & ~out_gnt_i;
    lock_sel_d = sel;
    if (push) rr_d = (int'(sel) == NumInp - 1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // Response side: head of the ID FIFO owns the current response beat.
  always_comb begin
    in_rvalid_o = '0;
    if (!empty) in_rvalid_o[head] = out_rvalid_i;
  end

  assign out_rready_o = in_rready_i[head] & ~empty;
  assign pop          = out_rvalid_i & out_rready_o;

  always_comb begin
    for (int i = 0; i < NumInp; i++) in_rdata_o[i] = out_rdata_i;
  end

  memory_island_port_arbiter_fifo #(
    .DataWidth (IdxWidth),
    .Depth     (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage)
  );

  // usage wraps to 0 at full, so the full flag supplies the top count.
  assign outstanding_o = full ? CntWidth'(MaxOutstanding) : CntWidth'(usage);

  a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> (in_req_i[lock_sel_q] && out_addr_o == $past(out_addr_o) && out_we_o == $past(out_we_o)
                && out_wdata_o == $past(out_wdata_o) && out_strb_o == $past(out_strb_o)));
  a_rvalid_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) out_rvalid_i |-> !empty);

endmodule
